y86_dmem: RTL and testbench

Parametrised data memory for the Y86 datapath. It replaces the fixed 20-word store with a DEPTH-word, WIDTH-bit array that uses byte addresses and a request/response handshake. The block adds a programmable access latency, a real write enable, and error reporting for misaligned and out-of-range accesses. It sits in the memory stage and serves one outstanding request at a time.

---
 rtl/y86_dmem.sv | 108 ++++++++++
 tb/tb_y86_dmem.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | y86_dmem                                                                  |
// | Byte-addressed DEPTH x WIDTH data memory with a fixed access latency and  |
// | a single-outstanding request/response handshake with error reporting.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module y86_dmem #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             res,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [63:0]      req_addr,
    input  logic [WIDTH-1:0] req_data,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    generate
        if (LAT < 1 || LAT > 7) begin : g_lat_check
            $error("y86_dmem: LAT must be in the range 1..7");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [2:0]       r_cnt;
    logic             r_write;
    logic [63:0]      r_addr;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [60:0]        w_index;
    logic [c_IDX_W-1:0] w_slot;
    logic               w_err;

    // Range check uses the full 61-bit word index so high address bits never alias.
    assign w_index = r_addr[63:3];
    assign w_slot  = r_addr[3 +: c_IDX_W];
    assign w_err   = (r_addr[2:0] != 3'd0) || (w_index >= 61'(DEPTH));

    assign req_ready  = (r_state == c_IDLE);
    assign resp_valid = (r_state == c_RESP);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state   <= c_IDLE;
            r_cnt     <= 3'd0;
            r_write   <= 1'b0;
            r_addr    <= 64'd0;
            r_data    <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_data  <= req_data;
                        r_cnt   <= 3'(LAT - 1);
                        r_state <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (r_cnt == 3'd0) begin
                        if (w_err) begin
                            resp_data <= '0;
                            resp_err  <= 1'b1;
                        end else if (r_write) begin
                            r_mem[w_slot] <= r_data;
                            resp_data     <= '0;
                            resp_err      <= 1'b0;
                        end else begin
                            resp_data <= r_mem[w_slot];
                            resp_err  <= 1'b0;
                        end
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_y86_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_y86_dmem                                                               |
// | Three instances (LAT = 2, 1, 7) share one request bus; responses are      |
// | checked against constant vectors and a word-array reference model.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_y86_dmem;

    localparam int N_INST = 3;
    localparam int LATS [N_INST] = '{2, 1, 7};

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr  = 64'd0;
    logic [63:0] req_data  = 64'd0;

    logic        req_ready  [N_INST];
    logic        resp_valid [N_INST];
    logic [63:0] resp_data  [N_INST];
    logic        resp_err   [N_INST];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    logic [63:0] mem_m [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    y86_dmem #(.WIDTH(64), .DEPTH(32), .LAT(2)) u_lat2 (
        .clk(clk), .res(res), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid[0]), .resp_data(resp_data[0]), .resp_err(resp_err[0]));

    y86_dmem #(.WIDTH(64), .DEPTH(32), .LAT(1)) u_lat1 (
        .clk(clk), .res(res), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid[1]), .resp_data(resp_data[1]), .resp_err(resp_err[1]));

    y86_dmem #(.WIDTH(64), .DEPTH(32), .LAT(7)) u_lat7 (
        .clk(clk), .res(res), .req_valid(req_valid), .req_ready(req_ready[2]),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid[2]), .resp_data(resp_data[2]), .resp_err(resp_err[2]));

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] ed;
        logic        ee;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem_m[i] = 64'd0;
    endtask

    // Applies one access to the reference array and returns the expected response.
    task automatic model_apply(input logic w, input logic [63:0] a, input logic [63:0] d,
                               output logic [63:0] ed, output logic ee);
        ee = (a % 8 != 0) || ((a / 8) >= 64'd32);
        ed = 64'd0;
        if (!ee) begin
            if (w) mem_m[a / 8] = d;
            else   ed = mem_m[a / 8];
        end
    endtask

    task automatic wait_all_ready();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready[0] && req_ready[1] && req_ready[2];
        end
        chk("ready_wait", 64'(ok), 64'd1);
    endtask

    // One request accepted by all instances in cycle c; each must answer at c+LAT+1.
    task automatic do_req(input string nm, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] ed, input logic ee);
        int          c;
        int          got_cyc [N_INST];
        int          n_pulse [N_INST];
        logic [63:0] got_d   [N_INST];
        logic        got_e   [N_INST];
        wait_all_ready();
        req_write = w;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        c = cyc;
        for (int k = 0; k < N_INST; k++) begin
            got_cyc[k] = -1;
            n_pulse[k] = 0;
            got_d[k]   = 64'hx;
            got_e[k]   = 1'bx;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = {$urandom, $urandom};
        req_data  = {$urandom, $urandom};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            for (int k = 0; k < N_INST; k++) begin
                if (resp_valid[k]) begin
                    n_pulse[k]++;
                    got_cyc[k] = cyc - c;
                    got_d[k]   = resp_data[k];
                    got_e[k]   = resp_err[k];
                end
            end
        end
        for (int k = 0; k < N_INST; k++) begin
            chk($sformatf("%s_lat%0d_pulses", nm, LATS[k]), 64'(n_pulse[k]), 64'd1);
            chk($sformatf("%s_lat%0d_latency", nm, LATS[k]), 64'(got_cyc[k]), 64'(LATS[k] + 1));
            chk($sformatf("%s_lat%0d_data", nm, LATS[k]), got_d[k], ed);
            chk($sformatf("%s_lat%0d_err", nm, LATS[k]), 64'(got_e[k]), 64'(ee));
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        for (int k = 0; k < N_INST; k++) begin
            chk($sformatf("%s_ready%0d", nm, k), 64'(req_ready[k]), 64'd1);
            chk($sformatf("%s_rvalid%0d", nm, k), 64'(resp_valid[k]), 64'd0);
            chk($sformatf("%s_rdata%0d", nm, k), resp_data[k], 64'd0);
            chk($sformatf("%s_rerr%0d", nm, k), 64'(resp_err[k]), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] ed;
        logic        ee;
        logic [63:0] a;
        logic [63:0] d;
        logic        w;
        int          acc_cnt  [N_INST];
        int          acc_first[N_INST];
        int          acc_gap  [N_INST];
        logic        prev_rv  [N_INST];
        int          dbl_pulse[N_INST];
        int          spurious;

        tbl[0]  = '{1'b0, 64'h00,  64'h0,                   64'h0,                   1'b0};
        tbl[1]  = '{1'b1, 64'h18,  64'hDEADBEEF_00000001,   64'h0,                   1'b0};
        tbl[2]  = '{1'b0, 64'h18,  64'h0,                   64'hDEADBEEF_00000001,   1'b0};
        tbl[3]  = '{1'b0, 64'h10,  64'h0,                   64'h0,                   1'b0};
        tbl[4]  = '{1'b1, 64'h1C,  64'h12345678_9ABCDEF0,   64'h0,                   1'b1};
        tbl[5]  = '{1'b0, 64'h18,  64'h0,                   64'hDEADBEEF_00000001,   1'b0};
        tbl[6]  = '{1'b1, 64'hF8,  64'hA5A5A5A5_5A5A5A5A,   64'h0,                   1'b0};
        tbl[7]  = '{1'b0, 64'hF8,  64'h0,                   64'hA5A5A5A5_5A5A5A5A,   1'b0};
        tbl[8]  = '{1'b1, 64'h100, 64'hFFFFFFFF_FFFFFFFF,   64'h0,                   1'b1};
        tbl[9]  = '{1'b0, 64'h100, 64'h0,                   64'h0,                   1'b1};
        tbl[10] = '{1'b0, 64'h00,  64'h0,                   64'h0,                   1'b0};
        tbl[11] = '{1'b0, 64'hF8,  64'h0,                   64'hA5A5A5A5_5A5A5A5A,   1'b0};

        model_clear();
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        res = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        for (int i = 0; i < 12; i++) begin
            model_apply(tbl[i].w, tbl[i].a, tbl[i].d, ed, ee);
            do_req($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ed, tbl[i].ee);
        end

        // Held req_valid: acceptances every LAT+2 cycles, one-cycle response pulses.
        wait_all_ready();
        for (int k = 0; k < N_INST; k++) begin
            acc_cnt[k] = 0; acc_first[k] = -1; acc_gap[k] = 0;
            prev_rv[k] = 1'b0; dbl_pulse[k] = 0;
        end
        req_write = 1'b0;
        req_addr  = 64'h18;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N_INST; k++) begin
                if (req_ready[k]) begin
                    if (acc_cnt[k] == 1) acc_gap[k] = i - acc_first[k];
                    if (acc_cnt[k] == 0) acc_first[k] = i;
                    acc_cnt[k]++;
                end
                if (resp_valid[k] && prev_rv[k]) dbl_pulse[k]++;
                prev_rv[k] = resp_valid[k];
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < N_INST; k++) begin
                if (resp_valid[k] && prev_rv[k]) dbl_pulse[k]++;
                prev_rv[k] = resp_valid[k];
            end
            @(negedge clk);
        end
        for (int k = 0; k < N_INST; k++) begin
            chk($sformatf("held_lat%0d_accepts", LATS[k]), 64'(acc_cnt[k]), 64'((8 + LATS[k] + 1) / (LATS[k] + 2)));
            chk($sformatf("held_lat%0d_dblpulse", LATS[k]), 64'(dbl_pulse[k]), 64'd0);
        end
        chk("held_lat2_gap", 64'(acc_gap[0]), 64'd4);
        chk("held_lat1_gap", 64'(acc_gap[1]), 64'd3);

        // Reset during BUSY drops the write and the response.
        wait_all_ready();
        req_write = 1'b1;
        req_addr  = 64'h8;
        req_data  = 64'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        model_clear();
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            for (int k = 0; k < N_INST; k++) if (resp_valid[k]) spurious++;
        end
        chk("reset_busy_no_resp", 64'(spurious), 64'd0);
        check_idle_outputs("reset_busy_idle");
        do_req("reset_busy_rd8", 1'b0, 64'h8, 64'h0, 64'h0, 1'b0);
        do_req("reset_busy_rdF8", 1'b0, 64'hF8, 64'h0, 64'h0, 1'b0);

        // Randomized traffic against the reference array.
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0:       a = 64'(8 * $urandom_range(0, 31) + $urandom_range(1, 7));
                1:       a = 64'(8 * $urandom_range(32, 40));
                2:       a = {32'($urandom_range(1, 255)), 24'd0, 5'($urandom_range(0, 31)), 3'd0};
                default: a = 64'(8 * $urandom_range(0, 31));
            endcase
            model_apply(w, a, d, ed, ee);
            do_req($sformatf("rnd%0d", i), w, a, d, ed, ee);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
